// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the sigma-delta receive path.
//   sd_ow()      - internal/output word width of a sinc3 decimator for a given log2(R)
//   SD_POS/NEG   - numeric values of bitstream bits 1 and 0
//   sd_sample_t  - signed sample word at the default decimation ratio, for downstream stages
`timescale 1ns/1ps
package sd_pkg;

  // Third-order CIC bit growth is 3*log2(R); +2 covers the +/-R**3 full-scale
  // swing including its positive endpoint.
  function automatic int sd_ow(input int log2r);
    return 3 * log2r + 2;
  endfunction

  localparam int SD_POS = 1;
  localparam int SD_NEG = -1;

  localparam int SD_LOG2R = 6;
  localparam int SD_OW    = sd_ow(SD_LOG2R);

  typedef logic signed [SD_OW-1:0] sd_sample_t;

endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: one enabled accumulator stage of a CIC filter.
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the accumulator
//   en    - accumulate din on this edge
//   din   - addend (modulo 2**W)
//   acc   - accumulator value; wraps freely
`timescale 1ns/1ps
module cic_integrator
  import sd_pkg::*;
#(
  parameter int W = SD_OW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/sd_decim3.sv
// sd_decim3: third-order CIC (sinc3) decimator for a 1-bit sigma-delta stream.
//   clk       - clock (modulator bit rate)
//   rst_n     - asynchronous active-low reset
//   bs_in     - bitstream bit, 1 = +1, 0 = -1
//   bs_valid  - bs_in is accepted this cycle
//   sd_out    - signed decimated sample, OW bits, held between pulses
//   out_valid - one-cycle strobe marking a new sd_out
`timescale 1ns/1ps
module sd_decim3
  import sd_pkg::*;
#(
  parameter int LOG2R = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bs_in,
  input  logic                          bs_valid,
  output logic signed [sd_ow(LOG2R)-1:0] sd_out,
  output logic                          out_valid
);

  localparam int OW = sd_ow(LOG2R);

  logic [OW-1:0]        x;
  logic [3:0][OW-1:0]   chain;    // chain[0] = x, chain[k] = integrator k output
  logic [LOG2R-1:0]     cnt;
  logic                 window_end;
  logic [OW-1:0]        dec_reg;
  logic                 dec_strobe;
  logic [OW-1:0]        d1, d2, d3;
  logic [OW-1:0]        c1, c2, c3;

  assign x        = bs_in ? OW'(SD_POS) : OW'(SD_NEG);
  assign chain[0] = x;

  // Each stage adds the pre-edge output of the previous one, so the cascade
  // is a pure register pipeline with no combinational adder chain.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_int
      cic_integrator #(.W(OW)) u_int (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bs_valid),
        .din   (chain[gi]),
        .acc   (chain[gi+1])
      );
    end
  endgenerate

  assign window_end = bs_valid && (cnt == {LOG2R{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      dec_reg    <= '0;
      dec_strobe <= 1'b0;
    end else begin
      if (bs_valid) begin
        cnt <= cnt + 1'b1;          // natural wrap from R-1 to 0
      end
      if (window_end) begin
        dec_reg <= chain[3];
      end
      dec_strobe <= window_end;
    end
  end

  // Comb section runs at the decimated rate; differences are modulo 2**OW,
  // which cancels any integrator wrap-around.
  assign c1 = dec_reg - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      sd_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dec_strobe;
      if (dec_strobe) begin
        d1     <= dec_reg;
        d2     <= c1;
        d3     <= c2;
        sd_out <= signed'(c3);
      end
    end
  end

endmodule

// File: tb/tb_sd_decim3.sv
// tb_sd_decim3: directed bench for sd_decim3 (R = 64, OW = 20).
`timescale 1ns/1ps
module tb_sd_decim3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               bs_in = 1'b0;
  logic               bs_valid = 1'b0;
  logic signed [19:0] sd_out;
  logic               out_valid;

  int n_vec = 0;
  int n_bad = 0;

  sd_decim3 #(.LOG2R(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bs_in     (bs_in),
    .bs_valid  (bs_valid),
    .sd_out    (sd_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  // Asynchronous assert with immediate output check, release on a falling edge.
  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    bs_valid = 1'b0;
    #1;
    check({tag, " sd_out"}, sd_out, 0);
    check({tag, " out_valid"}, out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives n_edges clock edges of one stimulus mode and checks every pulse:
  //   0 all ones, 1 all zeros, 2 alternating 1,0,..., 3 valid every other cycle,
  //   4 valid held low, 5/6 second-order modulator at 0.25 FS / 0.
  // Edges are numbered from 1; a pulse is attributed to the edge just before it.
  task automatic stream(input int mode, input int n_edges, input int exp_pulses,
                        input int exp_val, input int exp_gap, input int first_edge,
                        input string tag);
    int  pulses;
    int  last;
    real u, w, y, e1, e2;
    pulses = 0;
    last   = 0;
    e1     = 0.0;
    e2     = 0.0;
    u      = (mode == 5) ? 0.25 : 0.0;
    for (int e = 1; e <= n_edges; e++) begin
      case (mode)
        0: begin bs_valid = 1'b1; bs_in = 1'b1; end
        1: begin bs_valid = 1'b1; bs_in = 1'b0; end
        2: begin bs_valid = 1'b1; bs_in = e[0]; end
        3: begin bs_valid = e[0]; bs_in = 1'b1; end
        4: begin bs_valid = 1'b0; bs_in = e[0]; end
        default: begin
          // Error-feedback form with NTF (1 - z^-1)^2.
          w  = u - 2.0 * e1 + e2;
          y  = (w >= 0.0) ? 1.0 : -1.0;
          e2 = e1;
          e1 = y - w;
          bs_valid = 1'b1;
          bs_in    = (y > 0.0);
        end
      endcase
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (pulses == 1 && first_edge > 0)
          check({tag, " first pulse edge"}, e, first_edge);
        if (pulses > 1)
          check({tag, " pulse gap"}, e - last, exp_gap);
        if (pulses >= 4) begin
          if (mode >= 5)
            check_range({tag, " settled"}, sd_out, exp_val - 1311, exp_val + 1311);
          else
            check({tag, " settled"}, sd_out, exp_val);
        end
        last = e;
      end
    end
    check({tag, " pulse count"}, pulses, exp_pulses);
  endtask

  initial begin
    #2;
    do_reset("reset");
    stream(0, 385, 6, 262144, 64, 65, "ones");

    do_reset("reset2");
    stream(1, 385, 6, -262144, 64, 65, "zeros");

    do_reset("reset3");
    stream(2, 641, 10, 0, 64, 65, "alt");

    do_reset("reset4");
    stream(3, 768, 6, 262144, 128, 128, "half rate");
    stream(4, 500, 0, 0, 0, 0, "idle");
    check("idle sd_out held", sd_out, 262144);

    // 384 accepted bits so far leave cnt at 0; 30 more put it mid-window.
    stream(0, 30, 0, 0, 0, 0, "pre reset");
    #3;
    do_reset("mid reset");
    stream(0, 385, 6, 262144, 64, 65, "after reset");

    do_reset("reset5");
    stream(5, 513, 8, 65536, 64, 65, "loop 0.25");

    do_reset("reset6");
    stream(6, 513, 8, 0, 64, 65, "loop zero");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
